ram_dp_core: RTL and testbench
==============================

# ram_dp_core

Synchronous simple-dual-port RAM with one write channel and one read channel. It has a registered one-cycle read path, write-first collision bypass and per-location written-tracking with a read-error flag. This block is the DUT driven by the RAM UVM environment: the write agent drives the write channel and the read agent drives the read channel through the RAM interface.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each word.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words (16 by default).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request, sampled at the rising edge of clk.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request, sampled at the rising edge of clk.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data holds the result of the read sampled on the previous edge.
- rd_err  out  1  qualifies rd_valid: the location read had never been written since reset.

## Operation
Reset:
- Reset is asynchronous and active-low.
- While rstn=0, all array words are cleared to 0 and the written bitmap is cleared to all-0.
- While rstn=0: rd_data=0, rd_valid=0, rd_err=0.
- Requests are ignored while rstn=0.

Write:
- On an edge with wr_en=1: mem[wr_addr] <= wr_data and written[wr_addr] <= 1.
- A write has no response signal.

Read:
- On an edge with rd_en=1:
  - rd_data <= mem[rd_addr]
  - rd_valid <= 1
  - rd_err <= ~written[rd_addr]
- On an edge with rd_en=0: rd_valid <= 0 and rd_err <= 0; rd_data holds its last value.

Collision (rd_en=1, wr_en=1, rd_addr==wr_addr on the same edge):
- Write-first: rd_data <= wr_data, rd_err <= 0.
- The array is updated in the same edge.

Simultaneous read and write to different addresses:
- The two operations are fully independent.
- The read returns the old contents of rd_addr.

Addressing:
- All addresses 0..DEPTH-1 are legal; there is no out-of-range case.
- No wrap-around logic is needed.

Unwritten location:
- Reading an unwritten location returns 0, because reset cleared it, with rd_err=1.

Back-to-back:
- Reads and writes are accepted on every cycle with no stall.
- rd_valid stays high for consecutive read cycles.

Structure:
- Array as a register file so the asynchronous clear is legal.
- Written bitmap of DEPTH flops.
- Output registers for rd_data, rd_valid and rd_err.

## Timing
Read latency is exactly 1 cycle:
- rd_en sampled high at edge N gives rd_data, rd_valid and rd_err valid from just after edge N until edge N+1.

Write-to-read:
- A write at edge N is visible to a read sampled at edge N (through the bypass) and at any later edge.

Reset assertion:
- Outputs go to 0 immediately, without waiting for a clock edge.
- An in-flight read result is discarded: rd_valid drops in the same cycle.

Reset deassertion:
- The first request is sampled on the first rising edge after rstn goes high.
- The environment holds rd_en and wr_en at 0 during that edge; no synchronizer is required in this block.

Inputs:
- Inputs must be stable around the clk rising edge.
- No combinational path exists from any input to any output.

## Test plan
- Reset: drive rstn=0 mid-run after writing 0xA5 to address 3, then release and read address 3.
  - Response: rd_data=0x00, rd_valid=1 one cycle later, rd_err=1.
  - Outputs must be 0 during reset.
- Write then read: write 0x3C to address 7 at edge N, then rd_en with address 7 at edge N+2.
  - Response: after edge N+2, rd_data=0x3C, rd_valid=1, rd_err=0.
  - After edge N+3 with rd_en=0: rd_valid=0.
- Simultaneous same-address: at one edge, write 0x5A to address 2 with a read of address 2, where the old value is 0x11.
  - Response: rd_data=0x5A, rd_err=0.
  - A subsequent read of address 2 returns 0x5A.
- Simultaneous different-address: address 4 holds 0x22, address 5 holds 0x33. At one edge, write 0x77 to address 5 and read address 4.
  - Response: rd_data=0x22.
  - A following read of address 5 returns 0x77.
- Back-to-back: write addresses 0..15 with data 0xF0+addr on 16 consecutive cycles, then read 0..15 on 16 consecutive cycles.
  - Response: rd_valid high for 16 consecutive cycles, rd_data=0xF0..0xFF in order, rd_err=0 throughout.
- Reset mid-read: assert rstn=0 asynchronously in the cycle where rd_valid=1 returning 0x3C.
  - Response: rd_valid=0 and rd_data=0 immediately.
  - After release, a read of any address returns rd_err=1.

Source files
------------

// File: rtl/ram_dp_core.sv
// Simple-dual-port register-file RAM: one write port, one registered read port,
// write-first collision bypass and per-word written-tracking for rd_err.
module ram_dp_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_written;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_err;

  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_rd_unwritten;

  // Same-address write wins: forward the incoming data and treat it as written.
  always_comb begin
    w_collide      = wr_en && (wr_addr == rd_addr);
    w_rd_word      = r_mem[rd_addr];
    w_rd_unwritten = ~r_written[rd_addr];
    if (w_collide) begin
      w_rd_word      = wr_data;
      w_rd_unwritten = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_written <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr]     <= wr_data;
      r_written[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else if (rd_en) begin
      r_rd_data  <= w_rd_word;
      r_rd_valid <= 1'b1;
      r_rd_err   <= w_rd_unwritten;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_ram_dp_core.sv
// Bench for ram_dp_core: hand-computed vector table, directed reset and
// back-to-back sequences, then random traffic against an associative-array model.
module tb_ram_dp_core;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  ram_dp_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a word is "written" exactly when its key exists.
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_err;

  function automatic void model_reset();
    m_mem.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_edge(input logic we, input int wa, input logic [DW-1:0] wd,
                                     input logic re, input int ra);
    m_valid = re;
    m_err   = 1'b0;
    if (re) begin
      if (we && wa == ra) m_data = wd;
      else if (m_mem.exists(ra)) m_data = m_mem[ra];
      else begin
        m_data = '0;
        m_err  = 1'b1;
      end
    end
    if (we) m_mem[wa] = wd;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data"},  int'(rd_data),  int'(m_data));
    chk({tag, ".valid"}, int'(rd_valid), int'(m_valid));
    chk({tag, ".err"},   int'(rd_err),   int'(m_err));
  endtask

  // Drives one cycle, advances the model, samples 1 time unit after the edge.
  task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic re, input int ra);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    rd_en   = re;
    rd_addr = AW'(ra);
    model_edge(we, wa, wd, re, ra);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".data"},  int'(rd_data),  0);
    chk({tag, ".valid"}, int'(rd_valid), 0);
    chk({tag, ".err"},   int'(rd_err),   0);
  endtask

  typedef struct {
    logic          we;
    int            wa;
    logic [DW-1:0] wd;
    logic          re;
    int            ra;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //            we  wa  wd     re  ra  data   v  e
    vecs[0]  = '{1, 7, 8'h3C, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 7, 8'h3C, 1, 0};
    vecs[3]  = '{0, 0, 8'h00, 0, 0, 8'h3C, 0, 0};
    vecs[4]  = '{1, 2, 8'h11, 0, 0, 8'h3C, 0, 0};
    vecs[5]  = '{1, 2, 8'h5A, 1, 2, 8'h5A, 1, 0};
    vecs[6]  = '{0, 0, 8'h00, 1, 2, 8'h5A, 1, 0};
    vecs[7]  = '{1, 4, 8'h22, 0, 0, 8'h5A, 0, 0};
    vecs[8]  = '{1, 5, 8'h33, 0, 0, 8'h5A, 0, 0};
    vecs[9]  = '{1, 5, 8'h77, 1, 4, 8'h22, 1, 0};
    vecs[10] = '{0, 0, 8'h00, 1, 5, 8'h77, 1, 0};
    vecs[11] = '{0, 0, 8'h00, 1, 9, 8'h00, 1, 1};
    vecs[12] = '{1, 9, 8'h01, 1, 9, 8'h01, 1, 0};
    vecs[13] = '{0, 0, 8'h00, 0, 0, 8'h01, 0, 0};

    idle_inputs();
    model_reset();
    rstn = 1'b0;
    #2;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    check_zero("first_edge");

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      chk($sformatf("vec%0d.data", i),  int'(rd_data),  int'(vecs[i].exp_data));
      chk($sformatf("vec%0d.valid", i), int'(rd_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.err", i),   int'(rd_err),   int'(vecs[i].exp_err));
    end

    // Reset mid-read: write 0xA5 to 3, read it back, then reset while rd_valid=1.
    step(1, 3, 8'hA5, 0, 0);
    step(0, 0, 8'h00, 1, 3);
    chk("pre_rst.data",  int'(rd_data),  8'hA5);
    chk("pre_rst.valid", int'(rd_valid), 1);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    idle_inputs();
    @(negedge clk) rstn = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    check_zero("rst_release");
    step(0, 0, 8'h00, 1, 3);
    chk("rst_rd3.data",  int'(rd_data),  8'h00);
    chk("rst_rd3.valid", int'(rd_valid), 1);
    chk("rst_rd3.err",   int'(rd_err),   1);

    // Back-to-back writes then reads over the full address space.
    for (int a = 0; a < DEPTH; a++) step(1, a, DW'(8'hF0 + a), 0, 0);
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 0, 8'h00, 1, a);
      chk($sformatf("b2b%0d.data", a),  int'(rd_data),  8'hF0 + a);
      chk($sformatf("b2b%0d.valid", a), int'(rd_valid), 1);
      chk($sformatf("b2b%0d.err", a),   int'(rd_err),   0);
    end
    step(0, 0, 8'h00, 0, 0);
    chk("b2b_end.valid", int'(rd_valid), 0);
    chk("b2b_end.data",  int'(rd_data),  8'hFF);

    // Random traffic from a fresh reset so unwritten reads occur too.
    idle_inputs();
    #2 rstn = 1'b0;
    model_reset();
    @(negedge clk) rstn = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    check_model("rnd_start");
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           DW'($urandom), logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, DEPTH - 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
